iot_event_scheduler: RTL

Upstream stage of the active-IoT-device monitor counter. Watches the on/off status line of each of `N_DEV` devices, turns every status transition into a pending event, and serialises those events through a round-robin scheduler into at most one `change`/`on_off` pulse per clock. The monitor counter consumes the pulses directly, so concurrent device transitions are never lost or merged.

---
 rtl/iot_mon_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/iot_event_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/iot_mon_pkg.sv
// ============================================================================
// iot_mon_pkg : shared constants for the IoT monitor scheduler and counter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package iot_mon_pkg;

  localparam int N_DEV_DEFAULT = 8;

  localparam logic EV_OFF = 1'b0;
  localparam logic EV_ON  = 1'b1;

  // Device index width; at least one bit.
  function automatic int dev_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin search from a start pointer
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= WIDTH) begin
        w_idx = w_idx - WIDTH;
      end
      if (i_req[IDX_W'(w_idx)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iot_event_scheduler.sv
// ============================================================================
// iot_event_scheduler : per-device transition capture, serialised round-robin
//                       into one change/on_off pulse per clock.
// Optional: IOT_SCHED_SYNC2_EN adds a 2-flop synchroniser on dev_status.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module iot_event_scheduler
  import iot_mon_pkg::*;
#(
  parameter int N_DEV    = N_DEV_DEFAULT,
  parameter int DEV_ID_W = dev_id_w(N_DEV)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_DEV-1:0]    dev_status,
  input  logic                enable,
  output logic                change,
  output logic                on_off,
  output logic [DEV_ID_W-1:0] dev_id,
  output logic                busy
);

  logic [N_DEV-1:0]    w_s;
  logic [N_DEV-1:0]    w_edge;
  logic [N_DEV-1:0]    w_req;
  logic [N_DEV-1:0]    w_pend_nxt;
  logic [N_DEV-1:0]    w_dir_nxt;
  logic                w_gnt_valid;
  logic [DEV_ID_W-1:0] w_gnt_idx;
  logic                w_hit;

  logic [N_DEV-1:0]    r_prev;
  logic [N_DEV-1:0]    r_pend;
  logic [N_DEV-1:0]    r_dir;
  logic [DEV_ID_W-1:0] r_rr_ptr;
  logic                r_change;
  logic                r_on_off;
  logic [DEV_ID_W-1:0] r_dev_id;

`ifdef IOT_SCHED_SYNC2_EN
  logic [N_DEV-1:0] r_sync1;
  logic [N_DEV-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= dev_status;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = dev_status;
`endif

  assign w_edge = w_s ^ r_prev;
  assign w_req  = enable ? r_pend : '0;

  rr_arbiter #(
    .WIDTH (N_DEV),
    .IDX_W (DEV_ID_W)
  ) u_arb (
    .i_req         (w_req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_gnt_valid),
    .o_grant_idx   (w_gnt_idx)
  );

  // A grant always implies the bit was pending, so edge+grant re-arms with
  // the new direction while edge alone on a pending bit cancels it.
  always_comb begin
    w_pend_nxt = r_pend;
    w_dir_nxt  = r_dir;
    w_hit      = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      w_hit = w_gnt_valid && (int'(w_gnt_idx) == i);
      if (w_edge[i] && (!r_pend[i] || w_hit)) begin
        w_pend_nxt[i] = 1'b1;
        w_dir_nxt[i]  = w_s[i];
      end else if (w_edge[i] || w_hit) begin
        w_pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_pend   <= '0;
      r_dir    <= '0;
      r_rr_ptr <= '0;
      r_change <= 1'b0;
      r_on_off <= EV_OFF;
      r_dev_id <= '0;
    end else begin
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
      r_dir  <= w_dir_nxt;
      if (w_gnt_valid) begin
        r_change <= 1'b1;
        r_on_off <= r_dir[w_gnt_idx];
        r_dev_id <= w_gnt_idx;
        if (w_gnt_idx == DEV_ID_W'(N_DEV - 1)) begin
          r_rr_ptr <= '0;
        end else begin
          r_rr_ptr <= w_gnt_idx + DEV_ID_W'(1);
        end
      end else begin
        r_change <= 1'b0;
      end
    end
  end

  assign change = r_change;
  assign on_off = r_on_off;
  assign dev_id = r_dev_id;
  assign busy   = |r_pend;

endmodule

`default_nettype wire
